// File: rtl/mem_ctrl_if.sv
// Bundle of the IF/MEM requester handshakes and the byte-wide RAM bus seen by mem_ctrl.
interface mem_ctrl_if #(
  parameter int RAM_AW = 17
);
  logic              if_req_i;
  logic [31:0]       if_addr_i;
  logic [31:0]       if_data_o;
  logic              if_done_o;
  logic              mem_req_i;
  logic              mem_we_i;
  logic [31:0]       mem_addr_i;
  logic [3:0]        mem_sel_i;
  logic [31:0]       mem_data_i;
  logic [31:0]       mem_data_o;
  logic              mem_done_o;
  logic              stall_o;
  logic [RAM_AW-1:0] ram_addr_o;
  logic              ram_we_o;
  logic [7:0]        ram_dout_o;
  logic [7:0]        ram_din_i;

  // Controller side
  modport slave (
    input  if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i, ram_din_i,
    output if_data_o, if_done_o, mem_data_o, mem_done_o, stall_o, ram_addr_o, ram_we_o, ram_dout_o
  );

  // Requester / RAM side
  modport master (
    output if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i, ram_din_i,
    input  if_data_o, if_done_o, mem_data_o, mem_done_o, stall_o, ram_addr_o, ram_we_o, ram_dout_o
  );
endinterface

// File: rtl/mem_ctrl.sv
// Shared byte-wide RAM controller: arbitrates IF vs MEM (MEM wins), walks the selected
// byte lanes in ascending order, assembles load words and raises stall while busy.
module mem_ctrl #(
  parameter int RAM_AW = 17
) (
  input  logic      clk,
  input  logic      rst,
  mem_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic              gnt_mem_q;
  logic              we_q;
  logic              rd_pend_q;
  logic [3:0]        rem_q;
  logic [1:0]        rd_lane_q;
  logic [RAM_AW-1:0] base_q;
  logic [31:0]       wdata_q;
  logic [31:0]       asm_q;
  logic [31:0]       if_data_q;
  logic [31:0]       mem_data_q;

  logic              grant_mem;
  logic              grant_if;
  logic [31:0]       req_addr;
  logic [1:0]        cur_lane;
  logic [3:0]        rem_next;
  logic [31:0]       word_fin;
  logic [RAM_AW-1:0] ram_addr_d;
  logic              ram_we_d;
  logic [7:0]        ram_dout_d;
  logic              unused_addr_bits;

  // Lowest set lane of the remaining mask; lanes are issued in ascending order.
  function automatic logic [1:0] first_lane(input logic [3:0] m);
    logic [1:0] l;
    l = 2'd3;
    if (m[2]) l = 2'd2;
    if (m[1]) l = 2'd1;
    if (m[0]) l = 2'd0;
    return l;
  endfunction

  assign grant_mem = (state_q == IDLE) && bus.mem_req_i;
  assign grant_if  = (state_q == IDLE) && !bus.mem_req_i && bus.if_req_i;
  assign req_addr  = bus.mem_req_i ? bus.mem_addr_i : bus.if_addr_i;
  assign cur_lane  = first_lane(rem_q);
  assign rem_next  = rem_q & ~(4'b0001 << cur_lane);

  // Address bits above the RAM and the in-word offset carry no information here.
  assign unused_addr_bits = ^{req_addr[31:RAM_AW], req_addr[1:0]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and RAM bus drive; the RAM bus is idle (all zero) outside ACCESS.
  always_comb begin
    state_d    = state_q;
    ram_addr_d = '0;
    ram_we_d   = 1'b0;
    ram_dout_d = '0;
    case (state_q)
      IDLE: begin
        if (grant_mem)     state_d = (bus.mem_sel_i == 4'b0000) ? DONE : ACCESS;
        else if (grant_if) state_d = ACCESS;
      end
      ACCESS: begin
        ram_addr_d = base_q + RAM_AW'(cur_lane);
        ram_we_d   = we_q;
        if (we_q) ram_dout_d = wdata_q[{cur_lane, 3'b000} +: 8];
        if (rem_next == 4'b0000) state_d = we_q ? DONE : WAIT;
      end
      WAIT:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Final load word: the last byte arrives from the RAM during WAIT and is merged here.
  always_comb begin
    word_fin = asm_q;
    if (state_q == WAIT) word_fin[{rd_lane_q, 3'b000} +: 8] = bus.ram_din_i;
  end

  // Grant capture of the request control and the lane walk.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_mem_q <= 1'b0;
      we_q      <= 1'b0;
      rem_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_lane_q <= '0;
    end else if (grant_mem || grant_if) begin
      gnt_mem_q <= grant_mem;
      we_q      <= grant_mem && bus.mem_we_i;
      rem_q     <= grant_mem ? bus.mem_sel_i : 4'b1111;
      rd_pend_q <= 1'b0;
    end else if (state_q == ACCESS) begin
      rem_q     <= rem_next;
      rd_lane_q <= cur_lane;
      rd_pend_q <= !we_q;
    end
  end

  // Request data latches and read assembly; each byte lands one cycle after its address.
  always_ff @(posedge clk) begin
    if (grant_mem || grant_if) begin
      base_q  <= {req_addr[RAM_AW-1:2], 2'b00};
      wdata_q <= grant_mem ? bus.mem_data_i : '0;
      asm_q   <= '0;
    end else if (state_q == ACCESS && !we_q && rd_pend_q) begin
      asm_q[{rd_lane_q, 3'b000} +: 8] <= bus.ram_din_i;
    end
  end

  // Completion words, loaded on entry to DONE and held until the next completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_data_q  <= '0;
      mem_data_q <= '0;
    end else if (state_d == DONE && state_q != DONE) begin
      if (state_q == IDLE) mem_data_q <= '0;
      else if (gnt_mem_q)  mem_data_q <= we_q ? '0 : word_fin;
      else                 if_data_q  <= word_fin;
    end
  end

  assign bus.if_data_o  = if_data_q;
  assign bus.mem_data_o = mem_data_q;
  assign bus.if_done_o  = (state_q == DONE) && !gnt_mem_q;
  assign bus.mem_done_o = (state_q == DONE) && gnt_mem_q;
  assign bus.stall_o    = (bus.if_req_i && !bus.if_done_o) || (bus.mem_req_i && !bus.mem_done_o);
  assign bus.ram_addr_o = ram_addr_d;
  assign bus.ram_we_o   = ram_we_d;
  assign bus.ram_dout_o = ram_dout_d;
endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Single-port byte-wide RAM controller shared by the instruction-fetch stage (IF) and the memory-access stage (MEM).
- Arbitrates between the two requesters and serialises each 32-bit request into byte accesses, one per selected lane.
- Assembles read words and raises a stall while any request is outstanding.
- Sits between the IF/MEM stages and the 8-bit synchronous RAM, which has 1-cycle read latency.

Parameters:
- RAM_AW, 17: RAM byte-address width. Byte addresses wrap modulo 2^RAM_AW.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- if_req_i  in  1  IF fetch request, level, held until if_done_o
- if_addr_i  in  32  fetch address; bits [1:0] ignored
- if_data_o  out  32  fetched word
- if_done_o  out  1  one-cycle completion pulse
- mem_req_i  in  1  MEM request, level, held until mem_done_o
- mem_we_i  in  1  1 = store, 0 = load
- mem_addr_i  in  32  access address; bits [1:0] ignored (lanes come from sel)
- mem_sel_i  in  4  byte-lane enables; lane k = bits [8k+7:8k]
- mem_data_i  in  32  store data, lane-positioned
- mem_data_o  out  32  load data, lane-positioned; unselected lanes 0
- mem_done_o  out  1  one-cycle completion pulse
- stall_o  out  1  pipeline stall request
- ram_addr_o  out  RAM_AW  RAM byte address
- ram_we_o  out  1  RAM write enable
- ram_dout_o  out  8  RAM write data
- ram_din_i  in  8  RAM read data, valid one cycle after address

Behaviour:
- Reset (rst high at an edge):
  - state <= IDLE.
  - All outputs 0: if_data_o, mem_data_o, done pulses, ram_addr_o, ram_we_o, ram_dout_o.
  - Any in-flight access is abandoned and no done pulse is issued.
  - Bytes already written stay in RAM.
- States: IDLE, ACCESS, WAIT, DONE.
- Granting in IDLE:
  - Requests are sampled only in IDLE.
  - If mem_req_i is high, grant MEM (MEM has priority); otherwise, if if_req_i is high, grant IF.
  - At the grant edge, latch base = {addr[31:2], 2'b00} truncated to RAM_AW, the lane mask (IF: 4'b1111), the direction (IF is always a read) and the store data.
  - Call the grant edge cycle 0, and let n = number of set lanes.
- Lane ordering: selected lanes are issued in ascending order, with unselected lanes skipped.
- ACCESS, cycles 1..n:
  - Drive ram_addr_o = base + k for the current lane k, modulo 2^RAM_AW.
  - Store: ram_we_o = 1, ram_dout_o = data byte k.
  - Load: ram_we_o = 0; the byte is captured at the following edge into lane k of the assembly register.
- After the last lane:
  - Store: go to DONE, so the done pulse is in cycle n+1.
  - Load: go to WAIT for one cycle, capturing the last byte, then DONE, so the done pulse is in cycle n+2.
- sel = 4'b0000: IDLE -> DONE directly. The done pulse is in cycle 1, with no RAM activity and mem_data_o = 0.
- DONE (one cycle):
  - The granted requester's done output is 1.
  - Its data output holds the assembled word; unselected lanes are 0 and store data is 0.
  - Data outputs keep their value until that requester's next grant.
  - Next state is IDLE.
- Requester obligation: deassert req, or present a new request, by the edge that ends the done cycle. A request still high in IDLE is served again as a new request.
- Back-to-back: a new grant may happen at the edge ending the DONE state's IDLE cycle. The minimum gap between accesses is one IDLE cycle.
- Outputs while not in ACCESS: ram_addr_o = 0, ram_we_o = 0, ram_dout_o = 0.
- Request inputs must stay stable from grant until done. The controller uses latched copies.
- stall_o (combinational) = (if_req_i & ~if_done_o) | (mem_req_i & ~mem_done_o).
- A losing requester simply waits. No starvation guarantee for IF beyond MEM's one-request-per-instruction rate.

Test Plan:
- IF fetch: RAM[0x100..0x103] = 13 05 00 00, if_req_i with if_addr_i = 0x100. Required: ram_addr_o = 0x100, 0x101, 0x102, 0x103 in cycles 1-4; if_done_o in cycle 6; if_data_o = 0x00000513; stall_o high in cycles 0-5.
- Store byte: mem_we_i = 1, mem_addr_i = 0x202, sel = 0100, data = 0xABABABAB. Required: a single cycle with ram_we_o = 1, ram_addr_o = 0x202, ram_dout_o = 0xAB; mem_done_o in cycle 2; RAM[0x200], RAM[0x201] and RAM[0x203] unchanged.
- Load halfword: RAM[0x10..0x13] = 11 22 33 44, mem_addr_i = 0x12, sel = 1100. Required: ram_addr_o = 0x12, 0x13; mem_done_o in cycle 4; mem_data_o = 0x44330000.
- Contention: if_req_i and mem_req_i (LW) both rise in the same IDLE cycle. Required: MEM is granted first, with mem_done_o in cycle 6; IF is granted at the first IDLE edge after DONE; stall_o stays high throughout.
- Reset mid-store: SW of 0xDDCCBBAA at 0x40, with rst asserted after 2 write cycles. Required: ram_we_o = 0 on the next cycle, no mem_done_o pulse, RAM[0x40..0x41] = AA BB, RAM[0x42..0x43] unchanged. A new request after reset completes normally.
- Zero mask and wrap: sel = 0000 gives mem_done_o in cycle 1 with no ram_we_o. Separately, an IF fetch at 0x1FFFC with RAM_AW = 17 accesses 0x1FFFC..0x1FFFF.
